spi_slave_mot: RTL and testbench
================================

SPI_SLAVE_MOT -- requirements
Module: spi_slave_mot

Interface
REQ-001 Parameter FRAME_SIZE, default 8, SHALL set bits per SPI frame; legal range 4..16.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set flip-flop depth of input synchronizers; legal range 2..3.
REQ-003 PCLK  in  1  SHALL be the single block clock; all logic on rising edge.
REQ-004 PRESETN  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 SPISCLK  in  1  SHALL be the SPI serial clock from the master (Motorola mode 0, CPOL=0, CPHA=0).
REQ-006 SPISS  in  1  SHALL be the active-low slave select.
REQ-007 SPISDI  in  1  SHALL be serial data from master (MOSI).
REQ-008 SPISDO  out  1  SHALL be serial data to master (MISO), MSB first.
REQ-009 SPIOEN  out  1  SHALL be the SPISDO pad output enable, high while selected.
REQ-010 TX_DATA  in  FRAME_SIZE  SHALL be the next frame to transmit.
REQ-011 TX_VALID  in  1 / TX_READY  out  1  SHALL form a valid/ready handshake into a one-entry TX holding register.
REQ-012 RX_DATA  out  FRAME_SIZE  SHALL be the last complete received frame.
REQ-013 RX_VALID  out  1 / RX_READY  in  1  SHALL form a valid/ready handshake for RX_DATA.
REQ-014 TX_UNDERRUN, RX_OVERRUN  out  1 each  SHALL be single-PCLK status pulses.

Function
REQ-015 SPISCLK, SPISS, SPISDI SHALL pass through SYNC_STAGES synchronizers; edges detected on synchronized SPISCLK and SPISS; PCLK SHALL be >= 8x SPISCLK.
REQ-016 States: IDLE, SHIFT, WAIT_DESEL.
REQ-017 IDLE -> SHIFT on synchronized SPISS falling edge: bit counter cleared, TX shift register loaded from holding register (holding emptied) or all-zero with TX_UNDERRUN pulse if empty; SPISDO = shift MSB from next cycle.
REQ-018 SHIFT: on synchronized SPISCLK rising edge, synchronized SPISDI SHALL shift into RX shift register LSB-side and bit counter increments.
REQ-019 SHIFT: on synchronized SPISCLK falling edge, TX shift register SHALL shift left one bit, except after the FRAME_SIZE-th rising edge, when it reloads per REQ-017 rules (back-to-back frames under continuous SPISS low).
REQ-020 On FRAME_SIZE-th rising edge: RX_DATA updated, RX_VALID set next cycle, counter wraps to 0.
REQ-021 If RX_VALID high and RX_READY low when a new frame completes: RX_DATA overwritten, RX_VALID stays high, RX_OVERRUN pulses one cycle.
REQ-022 RX_VALID SHALL clear the cycle after RX_VALID && RX_READY, unless a frame completes that same cycle (then stays high, new data, no overrun).
REQ-023 TX_READY SHALL equal not(holding full); write accepted when TX_VALID && TX_READY.
REQ-024 Write accepted in the same cycle the empty holding register is sampled for load: underrun taken for current frame, written word kept for next frame.
REQ-025 SPISS rising edge in SHIFT: return IDLE; partial frame discarded, no RX_VALID, holding register untouched.
REQ-026 SPIOEN SHALL be high exactly in SHIFT; SPISDO SHALL be 0 outside SHIFT.

Reset
REQ-027 While PRESETN low: state IDLE, shift registers/counter/holding register cleared; SPISDO 0, SPIOEN 0, RX_DATA 0, RX_VALID 0, TX_UNDERRUN 0, RX_OVERRUN 0; TX_READY 1 once holding cleared.
REQ-028 If synchronized SPISS is low at reset release, state SHALL go to WAIT_DESEL and ignore SPI until SPISS seen high, then IDLE.

Structure
REQ-029 Package spi_slave_pkg SHALL hold the state enumeration and FRAME_SIZE/SYNC_STAGES defaults.
REQ-030 Sub-module spi_sync_edge (synchronizer + rise/fall pulse) SHALL be instantiated for SPISCLK and SPISS; SPISDI uses the same depth without edge detect.

Verification
REQ-031 Write TX_DATA=0xA5, SPISS low, master clocks 8 bits 0x3C at PCLK/16 -> MISO reads 0xA5, RX_DATA=0x3C with one RX_VALID, no status pulses.
REQ-032 No TX write, one 8-bit frame -> MISO 0x00, one TX_UNDERRUN pulse at SPISS fall.
REQ-033 SPISS low for frames 0x11, 0x22 with RX_READY held low -> RX_DATA=0x22, RX_VALID high, one RX_OVERRUN pulse.
REQ-034 SPISS deasserted after 5 bits -> no RX_VALID, SPIOEN low, next full frame 0x5A received correctly.
REQ-035 PRESETN pulsed low mid-frame with SPISS held low -> outputs at reset values, frame ignored until SPISS high then low; following frame 0xC3 received.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and defaults for the Motorola mode-0 SPI slave.
package spi_slave_pkg;

    localparam int FRAME_SIZE_DEF  = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SHIFT      = 2'd1,
        ST_WAIT_DESEL = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage input synchronizer with rise/fall pulses on the synced level.
module spi_sync_edge
    import spi_slave_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_mot.sv
// SPI slave, CPOL=0/CPHA=0, oversampled on PCLK with one-entry TX holding
// register and valid/ready RX output.
module spi_slave_mot
    import spi_slave_pkg::*;
#(
    parameter int FRAME_SIZE  = FRAME_SIZE_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  SPISCLK,
    input  logic                  SPISS,
    input  logic                  SPISDI,
    output logic                  SPISDO,
    output logic                  SPIOEN,
    input  logic [FRAME_SIZE-1:0] TX_DATA,
    input  logic                  TX_VALID,
    output logic                  TX_READY,
    output logic [FRAME_SIZE-1:0] RX_DATA,
    output logic                  RX_VALID,
    input  logic                  RX_READY,
    output logic                  TX_UNDERRUN,
    output logic                  RX_OVERRUN
);

    localparam int CW = $clog2(FRAME_SIZE);
    localparam logic [CW-1:0] LAST = CW'(FRAME_SIZE - 1);

    logic sclk_lvl_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic ss_q;
    logic ss_rise;
    logic ss_fall;

    logic [SYNC_STAGES-1:0] sdi_chain;
    logic                   sdi_q;

    state_t                state;
    logic [CW-1:0]         bit_cnt;
    logic [FRAME_SIZE-1:0] tx_sr;
    logic [FRAME_SIZE-1:0] rx_sr;
    logic [FRAME_SIZE-1:0] rx_next;
    logic [FRAME_SIZE-1:0] hold_data;
    logic                  hold_full;
    logic                  frame_end;
    logic                  reload_pend;
    logic                  reload_hit;
    logic                  wr_acc;

    spi_sync_edge #(
        .STAGES(SYNC_STAGES)
    ) u_sclk (
        .clk  (PCLK),
        .rst_n(PRESETN),
        .d    (SPISCLK),
        .q    (sclk_lvl_unused),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(
        .STAGES(SYNC_STAGES)
    ) u_ss (
        .clk  (PCLK),
        .rst_n(PRESETN),
        .d    (SPISS),
        .q    (ss_q),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    // Same depth as the SCLK path so data lines up with the edge pulse.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            sdi_chain <= '0;
        end else begin
            sdi_chain <= {sdi_chain[SYNC_STAGES-2:0], SPISDI};
        end
    end

    assign sdi_q    = sdi_chain[SYNC_STAGES-1];
    assign rx_next  = {rx_sr[FRAME_SIZE-2:0], sdi_q};
    assign TX_READY = ~hold_full;
    assign wr_acc   = TX_VALID & ~hold_full;
    assign SPIOEN   = (state == ST_SHIFT);
    assign SPISDO   = SPIOEN & tx_sr[FRAME_SIZE-1];

    // Back-to-back reloads are only committed at the next frame's first
    // rising edge, so a frame that ends with deselect leaves the holding
    // register and status untouched.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            frame_end   <= 1'b0;
            reload_pend <= 1'b0;
            reload_hit  <= 1'b0;
            RX_DATA     <= '0;
            RX_VALID    <= 1'b0;
            TX_UNDERRUN <= 1'b0;
            RX_OVERRUN  <= 1'b0;
        end else begin
            TX_UNDERRUN <= 1'b0;
            RX_OVERRUN  <= 1'b0;

            if (wr_acc) begin
                hold_data <= TX_DATA;
                hold_full <= 1'b1;
            end

            if (RX_VALID && RX_READY) begin
                RX_VALID <= 1'b0;
            end

            unique case (state)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state       <= ST_SHIFT;
                        bit_cnt     <= '0;
                        frame_end   <= 1'b0;
                        reload_pend <= 1'b0;
                        if (hold_full) begin
                            tx_sr     <= hold_data;
                            hold_full <= 1'b0;
                        end else begin
                            tx_sr       <= '0;
                            TX_UNDERRUN <= 1'b1;
                        end
                    end else if (!ss_q) begin
                        state <= ST_WAIT_DESEL;
                    end
                end

                ST_SHIFT: begin
                    if (ss_rise) begin
                        state       <= ST_IDLE;
                        bit_cnt     <= '0;
                        frame_end   <= 1'b0;
                        reload_pend <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            rx_sr <= rx_next;
                            if (reload_pend) begin
                                reload_pend <= 1'b0;
                                if (reload_hit) begin
                                    hold_full <= 1'b0;
                                end else begin
                                    TX_UNDERRUN <= 1'b1;
                                end
                            end
                            if (bit_cnt == LAST) begin
                                bit_cnt   <= '0;
                                frame_end <= 1'b1;
                                RX_DATA   <= rx_next;
                                RX_VALID  <= 1'b1;
                                if (RX_VALID && !RX_READY) begin
                                    RX_OVERRUN <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                        if (sclk_fall) begin
                            if (frame_end) begin
                                frame_end   <= 1'b0;
                                reload_pend <= 1'b1;
                                reload_hit  <= hold_full;
                                tx_sr       <= hold_full ? hold_data : '0;
                            end else begin
                                tx_sr <= tx_sr << 1;
                            end
                        end
                    end
                end

                ST_WAIT_DESEL: begin
                    if (ss_q) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_mot.sv
// Scoreboard bench for spi_slave_mot: bench acts as SPI master at PCLK/16.
module tb_spi_slave_mot;

    localparam int F    = 8;
    localparam int HALF = 8;

    logic         PCLK     = 1'b0;
    logic         PRESETN  = 1'b0;
    logic         SPISCLK  = 1'b0;
    logic         SPISS    = 1'b1;
    logic         SPISDI   = 1'b0;
    logic         SPISDO;
    logic         SPIOEN;
    logic [F-1:0] TX_DATA  = '0;
    logic         TX_VALID = 1'b0;
    logic         TX_READY;
    logic [F-1:0] RX_DATA;
    logic         RX_VALID;
    logic         RX_READY = 1'b1;
    logic         TX_UNDERRUN;
    logic         RX_OVERRUN;

    spi_slave_mot #(
        .FRAME_SIZE (F),
        .SYNC_STAGES(2)
    ) dut (
        .PCLK       (PCLK),
        .PRESETN    (PRESETN),
        .SPISCLK    (SPISCLK),
        .SPISS      (SPISS),
        .SPISDI     (SPISDI),
        .SPISDO     (SPISDO),
        .SPIOEN     (SPIOEN),
        .TX_DATA    (TX_DATA),
        .TX_VALID   (TX_VALID),
        .TX_READY   (TX_READY),
        .RX_DATA    (RX_DATA),
        .RX_VALID   (RX_VALID),
        .RX_READY   (RX_READY),
        .TX_UNDERRUN(TX_UNDERRUN),
        .RX_OVERRUN (RX_OVERRUN)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [F-1:0] exp_rx[$];
    logic [F-1:0] exp_miso[$];
    logic [F-1:0] wq[$];
    int           und_exp  = 0;
    int           ovr_exp  = 0;
    bit           tx_full_m = 1'b0;
    logic [F-1:0] tx_word_m = '0;
    bit           rx_held  = 1'b0;
    logic [F-1:0] rx_val_m = '0;

    // Monitor state
    int           und_seen   = 0;
    int           ovr_seen   = 0;
    bit           mon_ignore = 1'b0;
    logic         sclk_prev  = 1'b0;
    int           mbits      = 0;
    logic [F-1:0] mword      = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    always @(negedge PCLK) begin
        if (PRESETN) begin
            if (TX_UNDERRUN) und_seen++;
            if (RX_OVERRUN) ovr_seen++;
            if (RX_VALID && RX_READY) begin
                if (exp_rx.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_unexpected: got %0h expected none",
                             RX_DATA);
                end else begin
                    check("rx_data", 32'(RX_DATA), 32'(exp_rx.pop_front()));
                end
            end
        end
        if (SPISS || mon_ignore) begin
            mbits = 0;
        end else if (SPISCLK && !sclk_prev) begin
            mword = {mword[F-2:0], SPISDO};
            mbits++;
            if (mbits == F) begin
                mbits = 0;
                if (exp_miso.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL miso_unexpected: got %0h expected none",
                             mword);
                end else begin
                    check("miso", 32'(mword), 32'(exp_miso.pop_front()));
                end
            end
        end
        sclk_prev = SPISCLK;
    end

    task automatic clk_bits(logic [F-1:0] w, int n);
        for (int b = 0; b < n; b++) begin
            SPISDI = w[F-1-b];
            tick(HALF);
            SPISCLK = 1'b1;
            tick(HALF);
            SPISCLK = 1'b0;
        end
    endtask

    task automatic tx_write(logic [F-1:0] d);
        tick(1);
        TX_DATA  = d;
        TX_VALID = 1'b1;
        check("tx_ready_empty", 32'(TX_READY), 32'(!tx_full_m));
        tick(1);
        TX_VALID  = 1'b0;
        tx_full_m = 1'b1;
        tx_word_m = d;
        check("tx_ready_full", 32'(TX_READY), 0);
    endtask

    // One select period: nfr full frames then an optional partial frame.
    task automatic burst(int nfr, int part);
        logic [F-1:0] w;
        logic [F-1:0] m;
        int           nb;
        tick(4);
        SPISS = 1'b0;
        tick(HALF);
        check("oen_selected", 32'(SPIOEN), 1);
        for (int f = 0; f < nfr + (part > 0 ? 1 : 0); f++) begin
            w  = (wq.size() != 0) ? wq.pop_front() : F'($urandom);
            nb = (f < nfr) ? F : part;
            if (tx_full_m) begin
                m         = tx_word_m;
                tx_full_m = 1'b0;
            end else begin
                m = '0;
                und_exp++;
            end
            if (nb == F) begin
                exp_miso.push_back(m);
                if (RX_READY) begin
                    exp_rx.push_back(w);
                end else begin
                    if (rx_held) ovr_exp++;
                    rx_held  = 1'b1;
                    rx_val_m = w;
                end
            end
            clk_bits(w, nb);
        end
        tick(HALF);
        SPISS = 1'b1;
        tick(10);
    endtask

    task automatic release_rx();
        if (rx_held) begin
            exp_rx.push_back(rx_val_m);
            rx_held = 1'b0;
        end
        RX_READY = 1'b1;
        tick(4);
    endtask

    task automatic chk_status(string tag);
        check({tag, "_underruns"}, 32'(und_seen), 32'(und_exp));
        check({tag, "_overruns"}, 32'(ovr_seen), 32'(ovr_exp));
    endtask

    task automatic reset_mid_frame();
        mon_ignore = 1'b1;
        SPISS = 1'b0;
        und_exp++;
        tick(HALF);
        clk_bits(F'($urandom), 3);
        PRESETN = 1'b0;
        tick(3);
        check("rst_sdo", 32'(SPISDO), 0);
        check("rst_oen", 32'(SPIOEN), 0);
        check("rst_rx_valid", 32'(RX_VALID), 0);
        check("rst_rx_data", 32'(RX_DATA), 0);
        check("rst_tx_ready", 32'(TX_READY), 1);
        check("rst_underrun", 32'(TX_UNDERRUN), 0);
        check("rst_overrun", 32'(RX_OVERRUN), 0);
        PRESETN   = 1'b1;
        tx_full_m = 1'b0;
        tick(6);
        clk_bits(F'($urandom), F);
        tick(HALF);
        check("wait_desel_oen", 32'(SPIOEN), 0);
        check("wait_desel_rx_valid", 32'(RX_VALID), 0);
        SPISS = 1'b1;
        tick(10);
        mon_ignore = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nfr;
        int part;
        bit rdy_low;

        tick(3);
        check("reset_sdo", 32'(SPISDO), 0);
        check("reset_oen", 32'(SPIOEN), 0);
        check("reset_rx_valid", 32'(RX_VALID), 0);
        check("reset_rx_data", 32'(RX_DATA), 0);
        check("reset_tx_ready", 32'(TX_READY), 1);
        PRESETN = 1'b1;
        tick(10);

        // Loaded word out, 0x3C in
        wq.push_back(8'h3C);
        tx_write(8'hA5);
        burst(1, 0);
        chk_status("basic");

        // Empty holding register
        burst(1, 0);
        chk_status("underrun");

        // Two frames while consumer stalls
        RX_READY = 1'b0;
        wq.push_back(8'h11);
        wq.push_back(8'h22);
        burst(2, 0);
        check("ovr_rx_valid", 32'(RX_VALID), 1);
        check("ovr_rx_data", 32'(RX_DATA), 32'h22);
        release_rx();
        chk_status("overrun");

        // Aborted frame then a full one
        burst(0, 5);
        check("abort_oen", 32'(SPIOEN), 0);
        check("abort_rx_valid", 32'(RX_VALID), 0);
        wq.push_back(8'h5A);
        burst(1, 0);
        chk_status("abort");

        // Reset in the middle of a selected frame
        reset_mid_frame();
        wq.push_back(8'hC3);
        burst(1, 0);
        chk_status("midreset");

        for (int i = 0; i < 30; i++) begin
            rdy_low = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1 && !tx_full_m) begin
                tx_write(F'($urandom));
            end
            if (rdy_low) RX_READY = 1'b0;
            nfr  = $urandom_range(0, 3);
            part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, F - 1) : 0;
            if (nfr == 0 && part == 0) nfr = 1;
            burst(nfr, part);
            if (rdy_low) release_rx();
            chk_status("random");
        end

        tick(20);
        check("rx_queue_drained", 32'(exp_rx.size()), 0);
        check("miso_queue_drained", 32'(exp_miso.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
